// File: rtl/bomb_countdown_ctrl.sv
// Bomb game controller: BCD MM:SS countdown, wrong-code penalty drain,
// clear/fail decisions and the o_State code shared with the 1 s tick generator.
module bomb_countdown_ctrl #(
  parameter int unsigned INIT_MIN    = 1,
  parameter int unsigned INIT_SEC    = 0,
  parameter int unsigned PENALTY_SEC = 10,
  parameter int unsigned WARN_SEC    = 10
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Sec1Tick,
  input  logic       i_Start,
  input  logic       i_Defuse,
  input  logic       i_WrongCode,
  output logic [2:0] o_State,
  output logic [3:0] o_Min10,
  output logic [3:0] o_Min1,
  output logic [3:0] o_Sec10,
  output logic [3:0] o_Sec1,
  output logic       o_Warn,
  output logic       o_Boom
);

  typedef enum logic [2:0] {
    IDLE       = 3'b000,
    GAME_START = 3'b001,
    GAME_CLEAR = 3'b010,
    GAME_FAIL  = 3'b011
  } state_e;

  localparam logic [3:0] INIT_M10 = 4'(INIT_MIN / 10);
  localparam logic [3:0] INIT_M1  = 4'(INIT_MIN % 10);
  localparam logic [3:0] INIT_S10 = 4'(INIT_SEC / 10);
  localparam logic [3:0] INIT_S1  = 4'(INIT_SEC % 10);

  state_e     state_q, state_d;
  logic [3:0] min10_q, min10_d, min1_q, min1_d, sec10_q, sec10_d, sec1_q, sec1_d;
  logic [7:0] pen_q, pen_d;
  logic       warn_q, warn_d;
  logic       boom_q, boom_d;

  logic [3:0] dm10, dm1, ds10, ds1;
  logic [9:0] peff, peff_m1;
  logic [6:0] secs_d;

  // One-second BCD decrement of the current digits, clamped at 00:00.
  always_comb begin
    dm10 = min10_q;
    dm1  = min1_q;
    ds10 = sec10_q;
    ds1  = sec1_q;
    if ({min10_q, min1_q, sec10_q, sec1_q} != '0) begin
      if (sec1_q != 4'd0) begin
        ds1 = sec1_q - 4'd1;
      end else begin
        ds1 = 4'd9;
        if (sec10_q != 4'd0) begin
          ds10 = sec10_q - 4'd1;
        end else begin
          ds10 = 4'd5;
          if (min1_q != 4'd0) begin
            dm1 = min1_q - 4'd1;
          end else begin
            dm1  = 4'd9;
            dm10 = min10_q - 4'd1;
          end
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    min10_d = min10_q;
    min1_d  = min1_q;
    sec10_d = sec10_q;
    sec1_d  = sec1_q;
    pen_d   = pen_q;
    boom_d  = 1'b0;
    peff    = 10'(pen_q) + (i_WrongCode ? 10'(PENALTY_SEC) : '0) + 10'(i_Sec1Tick);
    peff_m1 = peff - 10'd1;

    case (state_q)
      IDLE: begin
        min10_d = INIT_M10;
        min1_d  = INIT_M1;
        sec10_d = INIT_S10;
        sec1_d  = INIT_S1;
        if (i_Start) begin
          state_d = GAME_START;
          pen_d   = '0;
        end
      end
      GAME_START: begin
        if (i_Defuse) begin
          state_d = GAME_CLEAR;
          pen_d   = '0;
        end else if (peff != '0) begin
          min10_d = dm10;
          min1_d  = dm1;
          sec10_d = ds10;
          sec1_d  = ds1;
          pen_d   = (peff_m1 > 10'd255) ? '1 : peff_m1[7:0];
          if ({dm10, dm1, ds10, ds1} == '0) begin
            state_d = GAME_FAIL;
            pen_d   = '0;
            boom_d  = 1'b1;
          end
        end
      end
      GAME_CLEAR, GAME_FAIL: begin
        if (i_Start) begin
          state_d = IDLE;
          min10_d = INIT_M10;
          min1_d  = INIT_M1;
          sec10_d = INIT_S10;
          sec1_d  = INIT_S1;
          pen_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Warning follows the next-state digits so it moves together with them.
    secs_d = 7'(sec10_d) * 7'd10 + 7'(sec1_d);
    warn_d = (state_d == GAME_START) && (min10_d == '0) && (min1_d == '0) &&
             (32'(secs_d) <= WARN_SEC);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= IDLE;
      min10_q <= INIT_M10;
      min1_q  <= INIT_M1;
      sec10_q <= INIT_S10;
      sec1_q  <= INIT_S1;
      pen_q   <= '0;
      warn_q  <= 1'b0;
      boom_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      min10_q <= min10_d;
      min1_q  <= min1_d;
      sec10_q <= sec10_d;
      sec1_q  <= sec1_d;
      pen_q   <= pen_d;
      warn_q  <= warn_d;
      boom_q  <= boom_d;
    end
  end

  assign o_State = state_q;
  assign o_Min10 = min10_q;
  assign o_Min1  = min1_q;
  assign o_Sec10 = sec10_q;
  assign o_Sec1  = sec1_q;
  assign o_Warn  = warn_q;
  assign o_Boom  = boom_q;

endmodule

// File: tb/tb_bomb_countdown_ctrl.sv
// Directed bench for bomb_countdown_ctrl: default 01:00 instance plus a 10:00
// instance used for the full borrow chain.
module tb_bomb_countdown_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0, start = 1'b0, defuse = 1'b0, wrong = 1'b0;
  logic [2:0] st, st2;
  logic [3:0] m10, m1, s10, s1;
  logic [3:0] m10b, m1b, s10b, s1b;
  logic       warn, boom, warn2, boom2;

  int checks = 0;
  int errors = 0;
  int rem;

  always #10 clk = ~clk;

  bomb_countdown_ctrl dut (
    .i_Clk(clk), .i_Rst(rst), .i_Sec1Tick(tick), .i_Start(start),
    .i_Defuse(defuse), .i_WrongCode(wrong), .o_State(st),
    .o_Min10(m10), .o_Min1(m1), .o_Sec10(s10), .o_Sec1(s1),
    .o_Warn(warn), .o_Boom(boom)
  );

  bomb_countdown_ctrl #(.INIT_MIN(10), .INIT_SEC(0), .PENALTY_SEC(10), .WARN_SEC(10)) dut2 (
    .i_Clk(clk), .i_Rst(rst), .i_Sec1Tick(tick), .i_Start(start),
    .i_Defuse(defuse), .i_WrongCode(wrong), .o_State(st2),
    .o_Min10(m10b), .o_Min1(m1b), .o_Sec10(s10b), .o_Sec1(s1b),
    .o_Warn(warn2), .o_Boom(boom2)
  );

  function automatic logic [15:0] bcd(input int s);
    int m;
    m = s / 60;
    return {4'(m / 10), 4'(m % 10), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic t, input logic s, input logic d, input logic w);
    tick = t; start = s; defuse = d; wrong = w;
    cyc();
    tick = 1'b0; start = 1'b0; defuse = 1'b0; wrong = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic [2:0] es, input logic [15:0] ed,
                           input logic ew, input logic eb);
    chk({tag, "_state"}, 32'(st), 32'(es));
    chk({tag, "_digits"}, 32'({m10, m1, s10, s1}), 32'(ed));
    chk({tag, "_warn"}, 32'(warn), 32'(ew));
    chk({tag, "_boom"}, 32'(boom), 32'(eb));
  endtask

  // Tick n times in GAME_START, checking the digits and warning after each.
  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      rem--;
      chk("tick_digits", 32'({m10, m1, s10, s1}), 32'(bcd(rem)));
      if (rem > 0) chk("tick_warn", 32'(warn), 32'(rem <= 10));
    end
  endtask

  initial begin
    // Test 1: reset, then countdown 01:00 -> 00:00
    cyc(); cyc();
    rst = 1'b0;
    check_all("reset", 3'b000, 16'h0100, 1'b0, 1'b0);
    chk("reset_dut2_digits", 32'({m10b, m1b, s10b, s1b}), 32'h1000);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check_all("idle_ignores_wrong", 3'b000, 16'h0100, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check_all("start", 3'b001, 16'h0100, 1'b0, 1'b0);
    rem = 60;
    run_ticks(1);
    // Test 2: borrow through every digit on the 10:00 instance
    chk("borrow_min10", 32'(m10b), 32'h0);
    chk("borrow_min1", 32'(m1b), 32'h9);
    chk("borrow_sec10", 32'(s10b), 32'h5);
    chk("borrow_sec1", 32'(s1b), 32'h9);
    run_ticks(59);
    check_all("fail_entry", 3'b011, 16'h0000, 1'b0, 1'b1);
    cyc();
    check_all("fail_boom_one_cycle", 3'b011, 16'h0000, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check_all("fail_to_idle", 3'b000, 16'h0100, 1'b0, 1'b0);

    // Test 3: penalty drains one second per clock from 00:25
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    rem = 60;
    run_ticks(35);
    chk("at_25", 32'({m10, m1, s10, s1}), 32'h0025);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    chk("pen_24", 32'({m10, m1, s10, s1}), 32'h0024);
    for (int i = 23; i >= 15; i--) begin
      cyc();
      chk("pen_drain", 32'({m10, m1, s10, s1}), 32'(bcd(i)));
    end
    cyc();
    check_all("pen_done_hold", 3'b001, 16'h0015, 1'b0, 1'b0);
    rem = 15;
    run_ticks(5);
    check_all("warn_at_10", 3'b001, 16'h0010, 1'b1, 1'b0);

    // Test 4: penalty plus late tick drains to 00:00
    run_ticks(5);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t4_04", 32'({m10, m1, s10, s1}), 32'h0004);
    cyc();
    chk("t4_03", 32'({m10, m1, s10, s1}), 32'h0003);
    cyc();
    chk("t4_02", 32'({m10, m1, s10, s1}), 32'h0002);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check_all("t4_01", 3'b001, 16'h0001, 1'b1, 1'b0);
    cyc();
    check_all("t4_fail", 3'b011, 16'h0000, 1'b0, 1'b1);
    cyc(); cyc(); cyc();
    check_all("t4_frozen", 3'b011, 16'h0000, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check_all("t4_idle", 3'b000, 16'h0100, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(); cyc();
    check_all("t4_no_residual_pen", 3'b001, 16'h0100, 1'b0, 1'b0);

    // Test 5: defuse wins over a simultaneous tick
    rem = 60;
    run_ticks(30);
    pulse(1'b1, 1'b0, 1'b1, 1'b0);
    check_all("clear", 3'b010, 16'h0030, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(); cyc();
    check_all("clear_frozen", 3'b010, 16'h0030, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check_all("clear_to_idle", 3'b000, 16'h0100, 1'b0, 1'b0);

    // Test 6: start ignored in game, reset mid-game with pending penalty
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    rem = 60;
    run_ticks(12);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t6_47", 32'({m10, m1, s10, s1}), 32'h0047);
    cyc(); cyc();
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check_all("start_ignored", 3'b001, 16'h0044, 1'b0, 1'b0);
    cyc(); cyc();
    check_all("at_42_p4", 3'b001, 16'h0042, 1'b0, 1'b0);
    rst = 1'b1;
    cyc();
    check_all("mid_reset", 3'b000, 16'h0100, 1'b0, 1'b0);
    cyc();
    rst = 1'b0;
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(); cyc();
    check_all("post_reset_pen_clear", 3'b001, 16'h0100, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
